ex_stage_md: RTL
================

# ex_stage_md

Parametrised successor to the single-cycle execute stage. It keeps the forwarding muxes, ALU path, branch and jump target computation and destination-register select. It adds an iterative multiply/divide unit with architectural HI/LO registers, which covers MIPS mult/multu/div/divu/mfhi/mflo/mthi/mtlo. The block sits between the ID/EX and EX/MEM pipeline registers and raises a stall to the hazard unit while a multiply/divide result is outstanding.

## Interface
- WIDTH, 32, datapath width in bits (even, ≥8)
- REG_AW, 5, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears HI, LO and the FSM
- ex_valid  in  1  a real instruction occupies EX this cycle (0 = bubble)
- ALUop  in  2  main-control ALU op (2'b10 = R-type, decode funct)
- funct  in  6  R-type function code
- ALUSrc, RegDst  in  1 each  operand-B select / Rd-vs-Rt select
- IDtoEX_PCadd4, IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm  in  WIDTH each  datapath inputs; Imm is already sign-extended
- j_address  in  26  jump field
- IDtoEX_Rt, IDtoEX_Rd  in  REG_AW each
- ForwardA, ForwardB  in  2 each  0 = register file, 1 = WB result, 2 = EX/MEM result, 3 = register file
- EXtoMEM_ALUresult, WB_ALUresult  in  WIDTH each  forwarding sources
- ALUresult  out  WIDTH  ALU result, or HI/LO for mfhi/mflo
- zero  out  1  ALUresult == 0
- EX_Rt  out  WIDTH  forwarded operand B (store data)
- RegDest  out  REG_AW  write destination
- Branch_Addr, Jump_address  out  WIDTH each  PCadd4 + (Imm<<2); {PCadd4[WIDTH-1:28], j_address, 2'b00}
- md_stall  out  1  hold IF/ID/EX and insert a bubble into MEM
- md_busy  out  1  the iterative unit is running

## Operation
- Combinational path: unchanged from the single-cycle stage for every funct except the eight MD codes 0x10–0x13 and 0x18–0x1B.
- MD decode requires ALUop == 2'b10 and ex_valid = 1.
- FSM states: IDLE, RUN, FIX.
  - IDLE → RUN on an accepted mult/multu/div/divu.
  - RUN lasts exactly WIDTH cycles; the counter counts WIDTH-1 down to 0.
  - RUN → FIX for one cycle, which applies the signs and writes HI/LO.
  - FIX → IDLE.
- Operand capture: at acceptance, the forwarded A (rs) and B (rt) values are latched into internal registers. Later changes on the inputs have no effect.
- Signed ops: operate on magnitudes. Product sign = sign A XOR sign B. Quotient truncates toward zero; remainder takes the dividend's sign. Unsigned ops skip the sign fix.
- Multiply: shift-add, 1 bit/cycle. Result {HI, LO} = 2·WIDTH-bit product.
- Divide: restoring, 1 bit/cycle. LO = quotient, HI = remainder.
- Divide by zero: HI = dividend (original, signed value), LO = all ones. Timing is unchanged; there is no trap.
- mthi/mtlo: write forwarded A into HI/LO at the clock edge (single cycle). ALUresult = 0; the RegDest value is don't-care because control disables the write.
- mfhi/mflo: ALUresult = HI/LO. The value must reflect any mthi/mtlo written in an earlier cycle.

## Timing
- Reset values: HI = LO = 0; FSM = IDLE; md_busy = md_stall = 0. All combinational outputs follow the inputs with zero latency.
- md_busy = 1 in RUN and FIX.
- md_stall is combinational. It is 1 when md_busy = 1 and the EX instruction is any MD op (mult/div/mf*/mt*). It is 0 for unrelated instructions, which flow through during RUN.
- Latency: an op accepted at edge N updates HI/LO at edge N+WIDTH+1. An mfhi held under stall completes in the cycle after FIX.
- A new mult/div arriving while busy stalls; it is accepted on the first IDLE cycle.
- mthi/mtlo while busy stall, so a late completion never overwrites them.
- ex_valid = 0 in EX: no acceptance and no stall contribution.
- Reset asserted mid-RUN: abort immediately to IDLE, and HI/LO = 0.

## Test plan
- Forwarding plus ALU: ReadData1 = 5, EXtoMEM = 7, ForwardA = 2, add with ReadData2 = 3 → ALUresult = 10, zero = 0; BEQ case with equal operands → zero = 1; Imm = 0xFFFF_FFFF, PCadd4 = 0x100 → Branch_Addr = 0xFC.
- multu 0xFFFF_FFFF × 2 → after 33 cycles HI = 1, LO = 0xFFFF_FFFE; md_busy is high for exactly 33 cycles.
- mult −3 × 5 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFF1. div −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- divu 9 / 0 → HI = 9, LO = 0xFFFF_FFFF. A following mflo stalls until FIX+1, then ALUresult = 0xFFFF_FFFF.
- During RUN: an independent add passes with md_stall = 0, while mthi during RUN asserts md_stall. After completion, mthi 0x1234 followed by mfhi returns 0x1234.
- Reset pulsed at RUN cycle 10 → md_busy = 0 on the same edge, HI = LO = 0, and the next mult runs the full WIDTH+1 cycles.

Source files
------------

// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
// master drives the ID/EX side; slave is the execute stage itself.
interface ex_stage_md_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic [1:0]        ALUop;
  logic [5:0]        funct;
  logic              ALUSrc;
  logic              RegDst;
  logic [WIDTH-1:0]  IDtoEX_PCadd4;
  logic [WIDTH-1:0]  IDtoEX_ReadData1;
  logic [WIDTH-1:0]  IDtoEX_ReadData2;
  logic [WIDTH-1:0]  IDtoEX_Imm;
  logic [25:0]       j_address;
  logic [REG_AW-1:0] IDtoEX_Rt;
  logic [REG_AW-1:0] IDtoEX_Rd;
  logic [1:0]        ForwardA;
  logic [1:0]        ForwardB;
  logic [WIDTH-1:0]  EXtoMEM_ALUresult;
  logic [WIDTH-1:0]  WB_ALUresult;

  logic [WIDTH-1:0]  ALUresult;
  logic              zero;
  logic [WIDTH-1:0]  EX_Rt;
  logic [REG_AW-1:0] RegDest;
  logic [WIDTH-1:0]  Branch_Addr;
  logic [WIDTH-1:0]  Jump_address;
  logic              md_stall;
  logic              md_busy;

  modport master (
    output ex_valid, ALUop, funct, ALUSrc, RegDst, IDtoEX_PCadd4,
           IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm, j_address,
           IDtoEX_Rt, IDtoEX_Rd, ForwardA, ForwardB, EXtoMEM_ALUresult,
           WB_ALUresult,
    input  ALUresult, zero, EX_Rt, RegDest, Branch_Addr, Jump_address,
           md_stall, md_busy
  );

  modport slave (
    input  ex_valid, ALUop, funct, ALUSrc, RegDst, IDtoEX_PCadd4,
           IDtoEX_ReadData1, IDtoEX_ReadData2, IDtoEX_Imm, j_address,
           IDtoEX_Rt, IDtoEX_Rd, ForwardA, ForwardB, EXtoMEM_ALUresult,
           WB_ALUresult,
    output ALUresult, zero, EX_Rt, RegDest, Branch_Addr, Jump_address,
           md_stall, md_busy
  );
endinterface

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with forwarding, ALU, branch/jump targets
// and an iterative 1-bit/cycle multiply/divide unit owning HI/LO.
module ex_stage_md #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  ex_stage_md_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PC_KEEP = ~WIDTH'(28'hFFF_FFFF);

  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               div_q, div_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   fwd_a, fwd_b, alu_b, alu_out, alu_result;
  logic [REG_AW-1:0]  reg_dest;
  logic               r_type, md_code, md_op, md_accept, mt_write;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b, mag_a, mag_b;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    case (bus.ForwardA)
      2'd1:    fwd_a = bus.WB_ALUresult;
      2'd2:    fwd_a = bus.EXtoMEM_ALUresult;
      default: fwd_a = bus.IDtoEX_ReadData1;
    endcase
    case (bus.ForwardB)
      2'd1:    fwd_b = bus.WB_ALUresult;
      2'd2:    fwd_b = bus.EXtoMEM_ALUresult;
      default: fwd_b = bus.IDtoEX_ReadData2;
    endcase
    alu_b    = bus.ALUSrc ? bus.IDtoEX_Imm : fwd_b;
    reg_dest = bus.RegDst ? bus.IDtoEX_Rd : bus.IDtoEX_Rt;
  end

  always_comb begin
    alu_out = '0;
    case (bus.ALUop)
      2'b00:   alu_out = fwd_a + alu_b;
      2'b01:   alu_out = fwd_a - alu_b;
      2'b11:   alu_out = fwd_a | alu_b;
      default: begin
        case (bus.funct)
          F_ADD, F_ADDU: alu_out = fwd_a + alu_b;
          F_SUB, F_SUBU: alu_out = fwd_a - alu_b;
          F_AND:         alu_out = fwd_a & alu_b;
          F_OR:          alu_out = fwd_a | alu_b;
          F_XOR:         alu_out = fwd_a ^ alu_b;
          F_NOR:         alu_out = ~(fwd_a | alu_b);
          F_SLT:         alu_out = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
          F_SLTU:        alu_out = {{(WIDTH-1){1'b0}}, fwd_a < alu_b};
          default:       alu_out = '0;
        endcase
      end
    endcase
  end

  // MD codes are 0x10-0x13 (mf/mt) and 0x18-0x1B (mult/div): funct = 01x0xx.
  always_comb begin
    r_type    = (bus.ALUop == 2'b10);
    md_code   = r_type && (bus.funct[5:4] == 2'b01) && !bus.funct[2];
    md_op     = bus.ex_valid && md_code;
    md_accept = md_op && bus.funct[3] && (state_q == S_IDLE);
    mt_write  = md_op && !bus.funct[3] && bus.funct[0] && !busy_q;
    if (md_code) begin
      if (!bus.funct[3] && !bus.funct[0]) alu_result = bus.funct[1] ? lo_q : hi_q;
      else                                alu_result = '0;
    end else begin
      alu_result = alu_out;
    end
  end

  always_comb begin
    in_mag_a = (!bus.funct[0] && fwd_a[WIDTH-1]) ? -fwd_a : fwd_a;
    in_mag_b = (!bus.funct[0] && fwd_b[WIDTH-1]) ? -fwd_b : fwd_b;
    mag_a    = (sgn_q && op_a_q[WIDTH-1]) ? -op_a_q : op_a_q;
    mag_b    = (sgn_q && op_b_q[WIDTH-1]) ? -op_b_q : op_b_q;

    mul_add  = acc_q[0] ? mag_a : '0;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: upper half is the partial remainder, lower half shifts
    // the dividend out and quotient bits in.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_trial >= {1'b0, mag_b});
    div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, mag_b}) : div_trial[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    prod   = (sgn_q && (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1])) ? -acc_q : acc_q;
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_q) begin
      if (op_b_q == '0) begin
        fix_hi = op_a_q;
        fix_lo = '1;
      end else begin
        fix_lo = (sgn_q && (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1])) ? -quo : quo;
        fix_hi = (sgn_q && op_a_q[WIDTH-1]) ? -rem : rem;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md_accept) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH-1);
          op_a_d  = fwd_a;
          op_b_d  = fwd_b;
          div_d   = bus.funct[1];
          sgn_d   = !bus.funct[0];
          acc_d   = {{WIDTH{1'b0}}, (bus.funct[1] ? in_mag_a : in_mag_b)};
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // mt* only reaches here when idle, so it can never collide with FIX.
    if (mt_write) begin
      if (bus.funct[1]) lo_d = fwd_a;
      else              hi_d = fwd_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.ALUresult    = alu_result;
  assign bus.zero         = (alu_result == '0);
  assign bus.EX_Rt        = fwd_b;
  assign bus.RegDest      = reg_dest;
  assign bus.Branch_Addr  = bus.IDtoEX_PCadd4 + (bus.IDtoEX_Imm << 2);
  assign bus.Jump_address = (bus.IDtoEX_PCadd4 & PC_KEEP) | WIDTH'({bus.j_address, 2'b00});
  assign bus.md_busy      = busy_q;
  assign bus.md_stall     = busy_q && md_op;
endmodule
